// File: rtl/cla_sat_pkg.sv
// -----------------------------------------------------------------------------
// cla_sat_pkg
// Shared definitions for the 8-bit saturating CLA arithmetic blocks:
// saturation limits, the subtract-accumulator state encoding and the
// per-operation clip flag pair.
// -----------------------------------------------------------------------------
package cla_sat_pkg;

  // Saturation limits for an 8-bit two's complement result
  localparam logic signed [7:0] SAT_MAX = 8'sh7F;  // +127
  localparam logic signed [7:0] SAT_MIN = 8'sh80;  // -128

  // Accumulator control states, explicit encoding for stable netlists
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Clip indication of one saturating operation
  typedef struct packed {
    logic ovf;  // result clipped to SAT_MAX
    logic uvf;  // result clipped to SAT_MIN
  } sat_flag_t;

endpackage

// File: rtl/cla_8bit_sat_sub.sv
// -----------------------------------------------------------------------------
// cla_8bit_sat_sub
// Combinational 8-bit signed saturating subtractor. Computes a - b as
// a + ~b + 1 through an 8-bit carry-lookahead adder with carry-in, then
// clamps the result to [-128, +127].
//
// Ports:
//   i_a     in   8  signed minuend
//   i_b     in   8  signed subtrahend (-128 is legal)
//   o_diff  out  8  saturated difference
//   o_flag  out  2  {ovf, uvf}: which limit the result was clipped to
// -----------------------------------------------------------------------------
module cla_8bit_sat_sub
  import cla_sat_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_diff,
  output sat_flag_t  o_flag
);

  // Every carry is expanded as g[i] | p[i]g[i-1] | ... | p[i..0]cin, so no
  // carry depends on a previously computed carry.
  function automatic logic [8:0] cla_carries(input logic [7:0] g,
                                             input logic [7:0] p,
                                             input logic       cin);
    logic [8:0] c;
    logic       term;
    logic       pp;
    c    = 9'd0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & cin);
    end
    return c;
  endfunction

  logic [7:0] w_b_inv;
  logic [7:0] w_gen;
  logic [7:0] w_prop;
  logic [8:0] w_carry;
  logic [7:0] w_raw;
  logic       w_clip;

  assign w_b_inv = ~i_b;
  assign w_gen   = i_a & w_b_inv;
  assign w_prop  = i_a ^ w_b_inv;
  assign w_carry = cla_carries(w_gen, w_prop, 1'b1);
  assign w_raw   = w_prop ^ w_carry[7:0];

  // Subtraction overflows only when the operand signs differ and the wrapped
  // result no longer carries the sign of a; the sign of a says which limit.
  // With b = -128 the ~b + 1 path still yields a + 128 mod 256, so the same
  // test covers it without a separate negation.
  assign w_clip = (i_a[7] != i_b[7]) && (w_raw[7] != i_a[7]);

  // Clamp the wrapped difference to the limit indicated by the overflow sign
  always_comb begin
    o_flag.ovf = w_clip & ~i_a[7];
    o_flag.uvf = w_clip & i_a[7];
    if (o_flag.ovf) begin
      o_diff = SAT_MAX;
    end else if (o_flag.uvf) begin
      o_diff = SAT_MIN;
    end else begin
      o_diff = w_raw;
    end
  end

endmodule

// File: rtl/cla_8bit_sat_sub_acc.sv
// -----------------------------------------------------------------------------
// cla_8bit_sat_sub_acc
// Sequential saturating subtract-accumulator. After a start it accepts LEN
// signed samples over a valid/ready handshake and performs
// acc <= sat(acc - b) on each one, keeping sticky clip flags and saturating
// clip counters for the burst. done pulses for one cycle after the last
// sample.
//
// Parameters: WIDTH (fixed 8), LEN (1..255 samples per burst), CNT_W.
// Ports:
//   i_clk       in   1      rising-edge clock
//   i_rst       in   1      asynchronous active-high reset
//   i_start     in   1      begin a burst (only honoured in IDLE)
//   i_init      in   WIDTH  accumulator seed, taken with an accepted start
//   i_in_valid  in   1      sample i_b is valid
//   o_in_ready  out  1      sample accepted this cycle if valid
//   i_b         in   WIDTH  signed subtrahend
//   o_acc       out  WIDTH  running saturated accumulator
//   o_done      out  1      one-cycle pulse when the burst completes
//   o_ovf       out  1      sticky: some step clipped to +127
//   o_uvf       out  1      sticky: some step clipped to -128
//   o_ovf_cnt   out  CNT_W  positive clips this burst, stops at all-ones
//   o_uvf_cnt   out  CNT_W  negative clips this burst, stops at all-ones
// -----------------------------------------------------------------------------
module cla_8bit_sat_sub_acc
  import cla_sat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 16,
  parameter int CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_init,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_acc,
  output logic                    o_done,
  output logic                    o_ovf,
  output logic                    o_uvf,
  output logic [CNT_W-1:0]        o_ovf_cnt,
  output logic [CNT_W-1:0]        o_uvf_cnt
);

  localparam logic [7:0]       LAST_IDX = 8'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_acc;
  logic                    r_in_ready;
  logic                    r_done;
  logic                    r_ovf;
  logic                    r_uvf;
  logic [CNT_W-1:0]        r_ovf_cnt;
  logic [CNT_W-1:0]        r_uvf_cnt;
  logic [7:0]              r_smp_idx;

  logic [7:0]              w_diff;
  sat_flag_t               w_flag;
  logic                    w_hs;

  cla_8bit_sat_sub u_sub (
    .i_a    (r_acc),
    .i_b    (i_b),
    .o_diff (w_diff),
    .o_flag (w_flag)
  );

  // in_ready is registered alongside the state, so it is exactly "state==RUN"
  assign w_hs = i_in_valid & r_in_ready;

  // Burst control FSM, accumulator, sticky flags and clip counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_uvf      <= 1'b0;
      r_ovf_cnt  <= '0;
      r_uvf_cnt  <= '0;
      r_smp_idx  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_acc      <= i_init;
            r_ovf      <= 1'b0;
            r_uvf      <= 1'b0;
            r_ovf_cnt  <= '0;
            r_uvf_cnt  <= '0;
            r_smp_idx  <= 8'd0;
            r_in_ready <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            r_acc <= w_diff;
            if (w_flag.ovf) begin
              r_ovf <= 1'b1;
              if (r_ovf_cnt != CNT_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
              end
            end
            if (w_flag.uvf) begin
              r_uvf <= 1'b1;
              if (r_uvf_cnt != CNT_MAX) begin
                r_uvf_cnt <= r_uvf_cnt + CNT_ONE;
              end
            end
            if (r_smp_idx == LAST_IDX) begin
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_smp_idx <= r_smp_idx + 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_in_ready <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_acc      = r_acc;
  assign o_done     = r_done;
  assign o_ovf      = r_ovf;
  assign o_uvf      = r_uvf;
  assign o_ovf_cnt  = r_ovf_cnt;
  assign o_uvf_cnt  = r_uvf_cnt;

endmodule

// File: doc/cla_8bit_sat_sub_acc.md
Name: cla_8bit_sat_sub_acc

Overview:
- Sequential saturating subtract-accumulator: the subtract direction of the team's 8-bit saturating CLA adder.
- Accepts a burst of LEN signed 8-bit samples over a valid/ready handshake and computes acc <= sat(acc - b) on each accepted sample.
- Reports the final saturated result plus sticky overflow/underflow flags and per-burst clip counters.
- Sits downstream of sample sources in the datapath; its results feed the same ovf/uvf reporting path as the adder.

Parameters:
- WIDTH, 8, data width; fixed at 8 for this revision; two's complement.
- LEN, 16, samples per burst; legal range 1..255.
- CNT_W, 8, width of each clip counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begins a burst; ignored unless state is IDLE
- init  input  WIDTH  signed accumulator seed, sampled when start is accepted
- in_valid  input  1  sample b is valid
- in_ready  output  1  block accepts a sample this cycle
- b  input  WIDTH  signed subtrahend
- acc  output  WIDTH  signed running saturated accumulator
- done  output  1  single-cycle pulse when the burst completes
- ovf  output  1  sticky: some step clipped to +127 during this burst
- uvf  output  1  sticky: some step clipped to -128 during this burst
- ovf_cnt  output  CNT_W  number of positive clips in this burst; saturates at all-ones
- uvf_cnt  output  CNT_W  number of negative clips in this burst; saturates at all-ones

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; acc=0; done=0; ovf=0; uvf=0; ovf_cnt=0; uvf_cnt=0; in_ready=0; sample counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → acc<=init, ovf/uvf/counters<=0, sample counter<=0, go to RUN.
- RUN:
  - in_ready=1.
  - A handshake (in_valid & in_ready) updates acc next edge: exact = acc - b, computed at 9 bits.
  - exact > 127 → acc=127, ovf<=1, ovf_cnt++.
  - exact < -128 → acc=-128, uvf<=1, uvf_cnt++.
  - Otherwise acc=exact.
  - b=-128 is legal; acc - (-128) is handled exactly at 9 bits, with no negation overflow.
  - Counter reaches LEN-1 on a handshake → go to DONE.
  - in_valid=0 → hold everything; no timeout.
- DONE:
  - done=1 for exactly one cycle; in_ready=0; go to IDLE.
- Latency:
  - 1 cycle from handshake to updated acc.
  - done is asserted the cycle after the last handshake.
- Holding:
  - acc, flags and counters hold in IDLE until the next start.
- start while in RUN or DONE is ignored.
- Counters stop at all-ones, never wrap.
- Flags are sticky for the burst and are cleared only by an accepted start or by rst.
- rst mid-burst → immediate return to the reset values; a partial burst produces no done.
- LEN=1 → exactly one handshake, then DONE.

Decomposition:
- Package cla_sat_pkg: SAT_MAX=127, SAT_MIN=-128, state enum (IDLE/RUN/DONE), sat_flag_t struct {ovf, uvf}.
- Sub-module cla_8bit_sat_sub: combinational, a - b implemented as a + ~b + 1 through the 8-bit CLA with carry-in.
  - Outputs: saturated diff, ovf, uvf.
  - Overflow detection: operand signs differ and the result sign differs from a.
- The top module owns the FSM, the handshake, the sample counter, and the sticky flags/counters.

Test Plan:
1. Normal burst, LEN=4: init=50, b={10,5,-20,3} → acc sequence 40,35,55,52; done one cycle after the 4th handshake; ovf=uvf=0; counters 0.
2. Positive clip, LEN=4: init=120, b={-10,-128,5,-1} → acc 127,127,122,123; ovf=1, ovf_cnt=2, uvf=0.
3. Negative clip, LEN=4: init=-120, b={10,127,-3,1} → acc -128,-128,-125,-126; uvf=1, uvf_cnt=2.
4. Handshake stalls: in_valid toggles 1,0,0,1,… with init=0, b=1 → acc changes only on handshake cycles; done after exactly LEN handshakes; start pulses during RUN are ignored.
5. Reset mid-burst: assert rst after 2 of 4 samples → all outputs 0 and state IDLE immediately; no done; a following start with init=7 runs a clean burst.
6. Counter saturation, CNT_W=2, LEN=6: init=127, b=-1 ×6 → ovf_cnt=3 (held), acc=127, ovf=1.
